// File: rtl/pueo_command_encoder.sv
// Command word builder for the SURF command link: one word per CMD_PERIOD clocks.
// Optional statistics counters are enabled with `define PUEO_CMDENC_STATS_EN.
module pueo_command_encoder #(
    parameter int CMD_PERIOD      = 8,
    parameter int TRIG_FIFO_DEPTH = 4
) (
    input  logic        sysclk_i,
    input  logic        sysclk_rst_i,
    input  logic        rundo_sync_i,
    input  logic        runrst_i,
    input  logic        runstop_i,
    input  logic        mode1_rst_i,
    input  logic [1:0]  fw_mark_i,
    input  logic        fw_mode_i,
    input  logic [7:0]  cmdproc_tdata,
    input  logic        cmdproc_tvalid,
    input  logic        cmdproc_tlast,
    output logic        cmdproc_tready,
    input  logic [7:0]  fw_tdata,
    input  logic        fw_tvalid,
    output logic        fw_tready,
    input  logic [13:0] trig_time_i,
    input  logic        trig_valid_i,
    output logic        trig_overflow_o,
`ifdef PUEO_CMDENC_STATS_EN
    output logic [15:0] msg_count_o,
    output logic [15:0] trig_count_o,
    output logic [15:0] trig_drop_count_o,
`endif
    output logic [31:0] command_o,
    output logic        command_valid_o
);

    localparam int PW = $clog2(CMD_PERIOD);
    localparam int AW = $clog2(TRIG_FIFO_DEPTH);

    logic [PW-1:0] phase;
    logic          rst_pend, stop_pend, sync_pend;
    logic          m1rst_pend, marka_pend, markb_pend;
    logic [13:0]   trig_mem [TRIG_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   trig_cnt;

    logic        build, eff_rst, eff_stop, eff_sync, eff_m1rst, eff_ma, eff_mb, spec_any;
    logic        cp_take, fw_take, m1_take, msg, pop, push_ok, ovf;
    logic [1:0]  runcmd, m1_type;
    logic [7:0]  m1_data;
    logic [13:0] trig_t;
    logic [31:0] word;

    // Sticky requests merge with same-cycle pulses so a build-cycle request makes that word.
    assign build     = &phase;
    assign eff_rst   = rst_pend   | runrst_i;
    assign eff_stop  = stop_pend  | runstop_i;
    assign eff_sync  = sync_pend  | rundo_sync_i;
    assign eff_m1rst = m1rst_pend | mode1_rst_i;
    assign eff_ma    = marka_pend | fw_mark_i[0];
    assign eff_mb    = markb_pend | fw_mark_i[1];
    assign spec_any  = eff_m1rst | eff_ma | eff_mb;

    assign cmdproc_tready = build & ~sysclk_rst_i & ~spec_any & ~fw_mode_i;
    assign fw_tready      = build & ~sysclk_rst_i & ~spec_any &  fw_mode_i;
    assign cp_take        = cmdproc_tvalid & cmdproc_tready;
    assign fw_take        = fw_tvalid & fw_tready;

    assign pop     = build & (trig_cnt != {(AW+1){1'b0}});
    assign push_ok = trig_valid_i & ((trig_cnt != (AW+1)'(TRIG_FIFO_DEPTH)) | pop);
    assign ovf     = trig_valid_i & ~push_ok;

    // Arbitrate the run command and the mode1 source for the word being built.
    always_comb begin
        runcmd  = 2'b00;
        m1_type = 2'b00;
        m1_data = 8'h00;
        m1_take = 1'b0;
        if (eff_rst)       runcmd = 2'b10;
        else if (eff_stop) runcmd = 2'b11;
        else if (eff_sync) runcmd = 2'b01;
        else               runcmd = 2'b00;

        if (eff_m1rst) begin
            m1_data = 8'h01;
            m1_take = 1'b1;
        end else if (eff_ma) begin
            m1_data = 8'h02;
            m1_take = 1'b1;
        end else if (eff_mb) begin
            m1_data = 8'h03;
            m1_take = 1'b1;
        end else if (fw_take) begin
            m1_type = 2'b11;
            m1_data = fw_tdata;
            m1_take = 1'b1;
        end else if (cp_take) begin
            m1_type = cmdproc_tlast ? 2'b11 : 2'b01;
            m1_data = cmdproc_tdata;
            m1_take = 1'b1;
        end else begin
            m1_take = 1'b0;
        end

        msg    = (runcmd != 2'b00) | m1_take;
        trig_t = pop ? trig_mem[rd_ptr] : 14'h0000;
        word   = {~msg, 3'b000, runcmd, m1_type, m1_data, pop, 1'b0, trig_t};
    end

    // Trigger queue storage; occupancy and pointers are reset in the main block.
    always_ff @(posedge sysclk_i) begin
        if (push_ok) trig_mem[wr_ptr] <= trig_time_i;
    end

    // Phase counter, pending flags, trigger pointers and the registered command word.
    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            phase           <= {PW{1'b0}};
            rst_pend        <= 1'b0;
            stop_pend       <= 1'b0;
            sync_pend       <= 1'b0;
            m1rst_pend      <= 1'b0;
            marka_pend      <= 1'b0;
            markb_pend      <= 1'b0;
            wr_ptr          <= {AW{1'b0}};
            rd_ptr          <= {AW{1'b0}};
            trig_cnt        <= {(AW+1){1'b0}};
            command_o       <= 32'h8000_0000;
            command_valid_o <= 1'b0;
            trig_overflow_o <= 1'b0;
        end else begin
            phase           <= phase + {{(PW-1){1'b0}}, 1'b1};
            command_valid_o <= build;
            trig_overflow_o <= ovf;
            if (build) begin
                // Only the highest-priority item is consumed; losers stay pending.
                rst_pend   <= 1'b0;
                stop_pend  <= eff_stop & eff_rst;
                sync_pend  <= eff_sync & (eff_rst | eff_stop);
                m1rst_pend <= 1'b0;
                marka_pend <= eff_ma & eff_m1rst;
                markb_pend <= eff_mb & (eff_m1rst | eff_ma);
                command_o  <= word;
            end else begin
                rst_pend   <= eff_rst;
                stop_pend  <= eff_stop;
                sync_pend  <= eff_sync;
                m1rst_pend <= eff_m1rst;
                marka_pend <= eff_ma;
                markb_pend <= eff_mb;
            end
            if (push_ok) wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            if (pop)     rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            trig_cnt <= trig_cnt + (AW+1)'(push_ok) - (AW+1)'(pop);
        end
    end

`ifdef PUEO_CMDENC_STATS_EN
    // Saturating statistics on built words and dropped triggers.
    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            msg_count_o       <= 16'h0000;
            trig_count_o      <= 16'h0000;
            trig_drop_count_o <= 16'h0000;
        end else begin
            if (build && msg && (msg_count_o != 16'hFFFF))
                msg_count_o <= msg_count_o + 16'h0001;
            if (pop && (trig_count_o != 16'hFFFF))
                trig_count_o <= trig_count_o + 16'h0001;
            if (ovf && (trig_drop_count_o != 16'hFFFF))
                trig_drop_count_o <= trig_drop_count_o + 16'h0001;
        end
    end
`endif

endmodule
